// File: rtl/result_forward_pipe.sv
// Result holding pipes between the even/odd execution pipes and the register file.
// Provides writeback from the oldest stage and youngest-first operand forwarding.
`timescale 1ns/1ps
module result_forward_pipe #(
  parameter int unsigned QUADWORD       = 128,
  parameter int unsigned REG_ADDR_WIDTH = 7,
  parameter int unsigned DEPTH          = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      even_res_vld,
  input  logic [QUADWORD-1:0]       even_res,
  input  logic [REG_ADDR_WIDTH-1:0] even_res_addr,
  input  logic                      odd_res_vld,
  input  logic [QUADWORD-1:0]       odd_res,
  input  logic [REG_ADDR_WIDTH-1:0] odd_res_addr,
  input  logic                      flush,
  input  logic [REG_ADDR_WIDTH-1:0] addr_ra_rd_even,
  input  logic [REG_ADDR_WIDTH-1:0] addr_rb_rd_even,
  input  logic [REG_ADDR_WIDTH-1:0] addr_rc_rd_even,
  input  logic [REG_ADDR_WIDTH-1:0] addr_ra_rd_odd,
  input  logic [REG_ADDR_WIDTH-1:0] addr_rb_rd_odd,
  input  logic [REG_ADDR_WIDTH-1:0] addr_rc_rd_odd,
  input  logic [QUADWORD-1:0]       rf_ra_even,
  input  logic [QUADWORD-1:0]       rf_rb_even,
  input  logic [QUADWORD-1:0]       rf_rc_even,
  input  logic [QUADWORD-1:0]       rf_ra_odd,
  input  logic [QUADWORD-1:0]       rf_rb_odd,
  input  logic [QUADWORD-1:0]       rf_rc_odd,
  output logic [QUADWORD-1:0]       fw_ra_even,
  output logic [QUADWORD-1:0]       fw_rb_even,
  output logic [QUADWORD-1:0]       fw_rc_even,
  output logic [QUADWORD-1:0]       fw_ra_odd,
  output logic [QUADWORD-1:0]       fw_rb_odd,
  output logic [QUADWORD-1:0]       fw_rc_odd,
  output logic [QUADWORD-1:0]       rt_wt_even,
  output logic [QUADWORD-1:0]       rt_wt_odd,
  output logic [REG_ADDR_WIDTH-1:0] addr_rt_wt_even,
  output logic [REG_ADDR_WIDTH-1:0] addr_rt_wt_odd,
  output logic                      regWr_en_even,
  output logic                      regWr_en_odd
);

  localparam int unsigned LAST = DEPTH - 1;
  localparam int unsigned NRD  = 6;

  logic [DEPTH-1:0]          even_vld_q, even_vld_d;
  logic [DEPTH-1:0]          odd_vld_q, odd_vld_d;
  logic [REG_ADDR_WIDTH-1:0] even_addr_q [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] even_addr_d [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] odd_addr_q  [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] odd_addr_d  [DEPTH];
  logic [QUADWORD-1:0]       even_data_q [DEPTH];
  logic [QUADWORD-1:0]       even_data_d [DEPTH];
  logic [QUADWORD-1:0]       odd_data_q  [DEPTH];
  logic [QUADWORD-1:0]       odd_data_d  [DEPTH];

  logic [REG_ADDR_WIDTH-1:0] rd_addr [NRD];
  logic [QUADWORD-1:0]       rf_data [NRD];
  logic [QUADWORD-1:0]       fw_data [NRD];
  logic                      wb_collide_c;

  // Shift by one stage; flush kills everything except the entry entering the last stage.
  always_comb begin : shift_next
    even_vld_d     = '0;
    odd_vld_d      = '0;
    even_vld_d[0]  = even_res_vld & ~flush;
    odd_vld_d[0]   = odd_res_vld & ~flush;
    even_addr_d[0] = even_res_addr;
    odd_addr_d[0]  = odd_res_addr;
    even_data_d[0] = even_res;
    odd_data_d[0]  = odd_res;
    for (int k = 1; k < int'(DEPTH); k++) begin
      even_vld_d[k]  = even_vld_q[k-1] & ~flush;
      odd_vld_d[k]   = odd_vld_q[k-1] & ~flush;
      even_addr_d[k] = even_addr_q[k-1];
      odd_addr_d[k]  = odd_addr_q[k-1];
      even_data_d[k] = even_data_q[k-1];
      odd_data_d[k]  = odd_data_q[k-1];
    end
    even_vld_d[LAST] = even_vld_q[LAST-1];
    odd_vld_d[LAST]  = odd_vld_q[LAST-1];
  end

  always_ff @(posedge clk or negedge reset) begin : stage_regs
    if (!reset) begin
      even_vld_q <= '0;
      odd_vld_q  <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        even_addr_q[k] <= '0;
        odd_addr_q[k]  <= '0;
        even_data_q[k] <= '0;
        odd_data_q[k]  <= '0;
      end
    end else begin
      even_vld_q <= even_vld_d;
      odd_vld_q  <= odd_vld_d;
      for (int k = 0; k < int'(DEPTH); k++) begin
        even_addr_q[k] <= even_addr_d[k];
        odd_addr_q[k]  <= odd_addr_d[k];
        even_data_q[k] <= even_data_d[k];
        odd_data_q[k]  <= odd_data_d[k];
      end
    end
  end

  // Odd wins a same-register writeback so the result is deterministic.
  assign wb_collide_c    = even_vld_q[LAST] & odd_vld_q[LAST] &
                           (even_addr_q[LAST] == odd_addr_q[LAST]);
  assign regWr_en_even   = even_vld_q[LAST] & ~wb_collide_c;
  assign regWr_en_odd    = odd_vld_q[LAST];
  assign addr_rt_wt_even = even_addr_q[LAST];
  assign addr_rt_wt_odd  = odd_addr_q[LAST];
  assign rt_wt_even      = even_data_q[LAST];
  assign rt_wt_odd       = odd_data_q[LAST];

  assign rd_addr[0] = addr_ra_rd_even;
  assign rd_addr[1] = addr_rb_rd_even;
  assign rd_addr[2] = addr_rc_rd_even;
  assign rd_addr[3] = addr_ra_rd_odd;
  assign rd_addr[4] = addr_rb_rd_odd;
  assign rd_addr[5] = addr_rc_rd_odd;
  assign rf_data[0] = rf_ra_even;
  assign rf_data[1] = rf_rb_even;
  assign rf_data[2] = rf_rc_even;
  assign rf_data[3] = rf_ra_odd;
  assign rf_data[4] = rf_rb_odd;
  assign rf_data[5] = rf_rc_odd;

  // Scan oldest to youngest, even before odd, so the last hit is the winner.
  always_comb begin : forward
    for (int o = 0; o < int'(NRD); o++) begin
      fw_data[o] = rf_data[o];
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (even_vld_q[k] && (even_addr_q[k] == rd_addr[o])) fw_data[o] = even_data_q[k];
        if (odd_vld_q[k] && (odd_addr_q[k] == rd_addr[o]))   fw_data[o] = odd_data_q[k];
      end
    end
  end

  assign fw_ra_even = fw_data[0];
  assign fw_rb_even = fw_data[1];
  assign fw_rc_even = fw_data[2];
  assign fw_ra_odd  = fw_data[3];
  assign fw_rb_odd  = fw_data[4];
  assign fw_rc_odd  = fw_data[5];

endmodule

// File: tb/tb_result_forward_pipe.sv
// Bench for result_forward_pipe: directed scenarios plus randomized traffic against
// a record-list model that tracks each result by the edge on which it was captured.
`timescale 1ns/1ps
module tb_result_forward_pipe;

  localparam int QW = 128;
  localparam int AW = 7;
  localparam int D  = 7;

  localparam logic [QW-1:0] ALL_A  = {16{8'hAA}};
  localparam logic [QW-1:0] ALL_11 = {16{8'h11}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          even_res_vld, odd_res_vld, flush;
  logic [QW-1:0] even_res, odd_res;
  logic [AW-1:0] even_res_addr, odd_res_addr;
  logic [AW-1:0] rd_addr [6];
  logic [QW-1:0] rf [6];
  logic [QW-1:0] fw [6];
  logic [QW-1:0] rt_wt_even, rt_wt_odd;
  logic [AW-1:0] addr_rt_wt_even, addr_rt_wt_odd;
  logic          regWr_en_even, regWr_en_odd;

  int tot_cnt  = 0;
  int pass_cnt = 0;

  result_forward_pipe #(.QUADWORD(QW), .REG_ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .even_res_vld(even_res_vld), .even_res(even_res), .even_res_addr(even_res_addr),
    .odd_res_vld(odd_res_vld), .odd_res(odd_res), .odd_res_addr(odd_res_addr),
    .flush(flush),
    .addr_ra_rd_even(rd_addr[0]), .addr_rb_rd_even(rd_addr[1]), .addr_rc_rd_even(rd_addr[2]),
    .addr_ra_rd_odd(rd_addr[3]), .addr_rb_rd_odd(rd_addr[4]), .addr_rc_rd_odd(rd_addr[5]),
    .rf_ra_even(rf[0]), .rf_rb_even(rf[1]), .rf_rc_even(rf[2]),
    .rf_ra_odd(rf[3]), .rf_rb_odd(rf[4]), .rf_rc_odd(rf[5]),
    .fw_ra_even(fw[0]), .fw_rb_even(fw[1]), .fw_rc_even(fw[2]),
    .fw_ra_odd(fw[3]), .fw_rb_odd(fw[4]), .fw_rc_odd(fw[5]),
    .rt_wt_even(rt_wt_even), .rt_wt_odd(rt_wt_odd),
    .addr_rt_wt_even(addr_rt_wt_even), .addr_rt_wt_odd(addr_rt_wt_odd),
    .regWr_en_even(regWr_en_even), .regWr_en_odd(regWr_en_odd)
  );

  // Model: each accepted result remembered with the edge that captured it.
  typedef struct {
    bit            odd;
    logic [AW-1:0] addr;
    logic [QW-1:0] data;
    int            born;
  } rec_t;
  rec_t q[$];
  int   edges = 0;

  function automatic logic [QW-1:0] rnd_qw();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void model_edge();
    rec_t nq[$];
    rec_t r;
    edges++;
    foreach (q[i]) begin
      int age = edges - q[i].born;
      if (age <= D - 1 && (!flush || age == D - 1)) nq.push_back(q[i]);
    end
    if (!flush && even_res_vld) begin
      r.odd = 1'b0; r.addr = even_res_addr; r.data = even_res; r.born = edges;
      nq.push_back(r);
    end
    if (!flush && odd_res_vld) begin
      r.odd = 1'b1; r.addr = odd_res_addr; r.data = odd_res; r.born = edges;
      nq.push_back(r);
    end
    q = nq;
  endfunction

  function automatic logic [QW-1:0] model_fwd(input logic [AW-1:0] a, input logic [QW-1:0] rfv);
    int best = D + 1;
    logic [QW-1:0] res = rfv;
    foreach (q[i]) begin
      int age = edges - q[i].born;
      if (q[i].addr == a && (age < best || (age == best && q[i].odd))) begin
        best = age;
        res  = q[i].data;
      end
    end
    return res;
  endfunction

  task automatic model_wb(input bit odd, output bit en, output logic [AW-1:0] a,
                          output logic [QW-1:0] dat);
    en = 1'b0; a = '0; dat = '0;
    foreach (q[i]) begin
      if (q[i].odd == odd && edges - q[i].born == D - 1) begin
        en = 1'b1; a = q[i].addr; dat = q[i].data;
      end
    end
    if (!odd && en) begin
      foreach (q[i]) if (q[i].odd && edges - q[i].born == D - 1 && q[i].addr == a) en = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    even_res_vld = 1'b0; even_res = '0; even_res_addr = '0;
    odd_res_vld  = 1'b0; odd_res  = '0; odd_res_addr  = '0;
    flush = 1'b0;
    for (int i = 0; i < 6; i++) begin rd_addr[i] = '0; rf[i] = '0; end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    rf[0] = ALL_A;
    #3;
    tot_cnt++; if (regWr_en_even !== 1'b0) $display("FAIL rst_en_even: got %b expected 0", regWr_en_even); else pass_cnt++;
    tot_cnt++; if (regWr_en_odd !== 1'b0) $display("FAIL rst_en_odd: got %b expected 0", regWr_en_odd); else pass_cnt++;
    tot_cnt++; if (fw[0] !== ALL_A) $display("FAIL rst_fw_ra_even: got %h expected %h", fw[0], ALL_A); else pass_cnt++;
    tot_cnt++; if (rt_wt_even !== '0 || rt_wt_odd !== '0) $display("FAIL rst_rt_wt: got %h/%h expected 0", rt_wt_even, rt_wt_odd); else pass_cnt++;
    tot_cnt++; if (addr_rt_wt_even !== '0 || addr_rt_wt_odd !== '0) $display("FAIL rst_addr: got %h/%h expected 0", addr_rt_wt_even, addr_rt_wt_odd); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      tot_cnt++; if (regWr_en_even !== 1'b0 || regWr_en_odd !== 1'b0) $display("FAIL rst_idle_en c=%0d: got %b%b expected 00", c, regWr_en_even, regWr_en_odd); else pass_cnt++;
    end
  endtask

  task automatic test_latency();
    for (int c = 0; c <= 9; c++) begin
      logic [QW-1:0] exp_fw;
      bit exp_en;
      tick();
      idle_inputs();
      rd_addr[0] = 7'd5;
      rf[0] = rnd_qw();
      if (c == 0) begin even_res_vld = 1'b1; even_res = ALL_11; even_res_addr = 7'd5; end
      #1;
      exp_en = (c == D);
      exp_fw = (c >= 1 && c <= D) ? ALL_11 : rf[0];
      tot_cnt++; if (regWr_en_even !== exp_en) $display("FAIL lat_en_even c=%0d: got %b expected %b", c, regWr_en_even, exp_en); else pass_cnt++;
      if (exp_en) begin
        tot_cnt++; if (addr_rt_wt_even !== 7'd5 || rt_wt_even !== ALL_11) $display("FAIL lat_wb_even: got %0d/%h expected 5/%h", addr_rt_wt_even, rt_wt_even, ALL_11); else pass_cnt++;
      end
      tot_cnt++; if (fw[0] !== exp_fw) $display("FAIL lat_fw c=%0d: got %h expected %h", c, fw[0], exp_fw); else pass_cnt++;
    end
  endtask

  task automatic test_youngest();
    for (int c = 0; c <= 10; c++) begin
      logic [QW-1:0] exp_fw;
      tick();
      idle_inputs();
      rd_addr[4] = 7'd9;
      rf[4] = rnd_qw();
      if (c == 0) begin even_res_vld = 1'b1; even_res = 128'h1; even_res_addr = 7'd9; end
      if (c == 2) begin odd_res_vld  = 1'b1; odd_res  = 128'h2; odd_res_addr  = 7'd9; end
      #1;
      if (c >= 1 && c <= 2)      exp_fw = 128'h1;
      else if (c >= 3 && c <= 9) exp_fw = 128'h2;
      else                       exp_fw = rf[4];
      tot_cnt++; if (fw[4] !== exp_fw) $display("FAIL young_fw c=%0d: got %h expected %h", c, fw[4], exp_fw); else pass_cnt++;
      tot_cnt++; if (regWr_en_even !== (c == 7)) $display("FAIL young_en_even c=%0d: got %b", c, regWr_en_even); else pass_cnt++;
      tot_cnt++; if (regWr_en_odd !== (c == 9)) $display("FAIL young_en_odd c=%0d: got %b", c, regWr_en_odd); else pass_cnt++;
      if (c == 7) begin
        tot_cnt++; if (rt_wt_even !== 128'h1 || addr_rt_wt_even !== 7'd9) $display("FAIL young_wb_even: got %0d/%h expected 9/1", addr_rt_wt_even, rt_wt_even); else pass_cnt++;
      end
      if (c == 9) begin
        tot_cnt++; if (rt_wt_odd !== 128'h2 || addr_rt_wt_odd !== 7'd9) $display("FAIL young_wb_odd: got %0d/%h expected 9/2", addr_rt_wt_odd, rt_wt_odd); else pass_cnt++;
      end
    end
  endtask

  task automatic test_collision();
    for (int c = 0; c <= 8; c++) begin
      logic [QW-1:0] exp0, exp3;
      tick();
      idle_inputs();
      rd_addr[0] = 7'd3; rd_addr[3] = 7'd3;
      rf[0] = rnd_qw(); rf[3] = rnd_qw();
      if (c == 0) begin
        even_res_vld = 1'b1; even_res = 128'h0E; even_res_addr = 7'd3;
        odd_res_vld  = 1'b1; odd_res  = 128'h0F; odd_res_addr  = 7'd3;
      end
      #1;
      exp0 = (c >= 1 && c <= D) ? 128'h0F : rf[0];
      exp3 = (c >= 1 && c <= D) ? 128'h0F : rf[3];
      tot_cnt++; if (fw[0] !== exp0) $display("FAIL coll_fw_ra_even c=%0d: got %h expected %h", c, fw[0], exp0); else pass_cnt++;
      tot_cnt++; if (fw[3] !== exp3) $display("FAIL coll_fw_ra_odd c=%0d: got %h expected %h", c, fw[3], exp3); else pass_cnt++;
      tot_cnt++; if (regWr_en_even !== 1'b0) $display("FAIL coll_en_even c=%0d: got %b expected 0", c, regWr_en_even); else pass_cnt++;
      tot_cnt++; if (regWr_en_odd !== (c == 7)) $display("FAIL coll_en_odd c=%0d: got %b", c, regWr_en_odd); else pass_cnt++;
      if (c == 7) begin
        tot_cnt++; if (rt_wt_odd !== 128'h0F || addr_rt_wt_odd !== 7'd3) $display("FAIL coll_wb_odd: got %0d/%h expected 3/f", addr_rt_wt_odd, rt_wt_odd); else pass_cnt++;
      end
    end
  endtask

  task automatic test_flush();
    for (int c = 0; c <= 13; c++) begin
      logic [QW-1:0] exp_fw;
      tick();
      idle_inputs();
      rd_addr[1] = 7'd1;
      rf[1] = rnd_qw();
      if (c <= 6) begin even_res_vld = 1'b1; even_res = QW'(c + 1); even_res_addr = 7'd1; end
      flush = (c == 6);
      #1;
      if (c >= 1 && c <= 6) exp_fw = QW'(c);
      else if (c == 7)      exp_fw = QW'(1);
      else                  exp_fw = rf[1];
      tot_cnt++; if (fw[1] !== exp_fw) $display("FAIL flush_fw c=%0d: got %h expected %h", c, fw[1], exp_fw); else pass_cnt++;
      tot_cnt++; if (regWr_en_even !== (c == 7) || regWr_en_odd !== 1'b0) $display("FAIL flush_en c=%0d: got %b%b", c, regWr_en_even, regWr_en_odd); else pass_cnt++;
      if (c == 7) begin
        tot_cnt++; if (rt_wt_even !== QW'(1) || addr_rt_wt_even !== 7'd1) $display("FAIL flush_wb: got %0d/%h expected 1/1", addr_rt_wt_even, rt_wt_even); else pass_cnt++;
      end
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c <= 7; c++) begin
      tick();
      idle_inputs();
      rd_addr[0] = 7'd2;
      rf[0] = rnd_qw();
      if (c == 0) begin even_res_vld = 1'b1; even_res = 128'hA; even_res_addr = 7'd2; end
      if (c == 1) begin odd_res_vld  = 1'b1; odd_res  = 128'hB; odd_res_addr  = 7'd4; end
      if (c == 2) begin even_res_vld = 1'b1; even_res = 128'hC; even_res_addr = 7'd6; end
      #1;
    end
    tot_cnt++; if (regWr_en_even !== 1'b1) $display("FAIL arst_pre_en: got %b expected 1", regWr_en_even); else pass_cnt++;
    #2 reset = 1'b0;
    q.delete();
    #1;
    tot_cnt++; if (regWr_en_even !== 1'b0 || regWr_en_odd !== 1'b0) $display("FAIL arst_en: got %b%b expected 00", regWr_en_even, regWr_en_odd); else pass_cnt++;
    tot_cnt++; if (fw[0] !== rf[0]) $display("FAIL arst_fw: got %h expected %h", fw[0], rf[0]); else pass_cnt++;
    tot_cnt++; if (rt_wt_even !== '0) $display("FAIL arst_rt_wt: got %h expected 0", rt_wt_even); else pass_cnt++;
    tick(); tick();
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      tot_cnt++; if (regWr_en_even !== 1'b0 || regWr_en_odd !== 1'b0) $display("FAIL arst_post_en c=%0d: got %b%b expected 00", c, regWr_en_even, regWr_en_odd); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bit            en_e, en_o;
      logic [AW-1:0] a_e, a_o;
      logic [QW-1:0] d_e, d_o, exp_fw;
      tick();
      even_res_vld = 1'($urandom_range(1, 0)); even_res = rnd_qw(); even_res_addr = AW'($urandom_range(7, 0));
      odd_res_vld  = 1'($urandom_range(1, 0)); odd_res  = rnd_qw(); odd_res_addr  = AW'($urandom_range(7, 0));
      flush = ($urandom_range(15, 0) == 0);
      for (int i = 0; i < 6; i++) begin rd_addr[i] = AW'($urandom_range(7, 0)); rf[i] = rnd_qw(); end
      #1;
      for (int i = 0; i < 6; i++) begin
        exp_fw = model_fwd(rd_addr[i], rf[i]);
        tot_cnt++; if (fw[i] !== exp_fw) $display("FAIL rnd_fw%0d c=%0d: got %h expected %h", i, c, fw[i], exp_fw); else pass_cnt++;
      end
      model_wb(1'b0, en_e, a_e, d_e);
      model_wb(1'b1, en_o, a_o, d_o);
      tot_cnt++; if (regWr_en_even !== en_e) $display("FAIL rnd_en_even c=%0d: got %b expected %b", c, regWr_en_even, en_e); else pass_cnt++;
      tot_cnt++; if (regWr_en_odd !== en_o) $display("FAIL rnd_en_odd c=%0d: got %b expected %b", c, regWr_en_odd, en_o); else pass_cnt++;
      if (en_e) begin
        tot_cnt++; if (addr_rt_wt_even !== a_e || rt_wt_even !== d_e) $display("FAIL rnd_wb_even c=%0d: got %0d/%h expected %0d/%h", c, addr_rt_wt_even, rt_wt_even, a_e, d_e); else pass_cnt++;
      end
      if (en_o) begin
        tot_cnt++; if (addr_rt_wt_odd !== a_o || rt_wt_odd !== d_o) $display("FAIL rnd_wb_odd c=%0d: got %0d/%h expected %0d/%h", c, addr_rt_wt_odd, rt_wt_odd, a_o, d_o); else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_youngest();
    test_collision();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
